// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline with branch resolution in ID and
// a multi-cycle mul/div unit in EX. Produces forwarding selects for EX and
// for the ID branch comparator. Produces stall/flush controls for load-use,
// branch-compare and mul/div-busy hazards. Also tracks a saturating count of
// stalled cycles.
//
// Mul/div sequencer states:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | unit free; a start that is not squashed by flush_E launches it
//   ST_BUSY | operation in flight; cnt counts down to 0 on the final cycle
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_rs_D,
  input  logic [REG_AW-1:0] i_rt_D,
  input  logic              i_branch_D,
  input  logic              i_pc_src_D,
  input  logic              i_md_use_D,
  input  logic [REG_AW-1:0] i_rs_E,
  input  logic [REG_AW-1:0] i_rt_E,
  input  logic [REG_AW-1:0] i_write_reg_E,
  input  logic              i_reg_write_E,
  input  logic              i_mem_to_reg_E,
  input  logic              i_md_start_E,
  input  logic [REG_AW-1:0] i_write_reg_M,
  input  logic              i_reg_write_M,
  input  logic              i_mem_to_reg_M,
  input  logic [REG_AW-1:0] i_write_reg_W,
  input  logic              i_reg_write_W,
  output logic [1:0]        o_forward_a_E,
  output logic [1:0]        o_forward_b_E,
  output logic              o_forward_a_D,
  output logic              o_forward_b_D,
  output logic              o_stall_F,
  output logic              o_stall_D,
  output logic              o_flush_D,
  output logic              o_flush_E,
  output logic              o_md_busy,
  output logic              o_md_done,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int                MD_CW   = $clog2(MD_LAT);
  localparam logic [MD_CW-1:0]  MD_LOAD = MD_CW'(MD_LAT - 1);
  localparam logic [1:0]        FWD_RF  = 2'b00;
  localparam logic [1:0]        FWD_MEM = 2'b10;
  localparam logic [1:0]        FWD_WB  = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  md_state_t        r_md_state;
  logic [MD_CW-1:0] r_md_cnt;
  logic             r_md_busy;
  logic             r_md_done;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_fwd_a_E;
  logic [1:0] w_fwd_b_E;
  logic       w_fwd_a_D;
  logic       w_fwd_b_D;
  logic       w_lw_stall;
  logic       w_br_stall;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_flush_D;

  // Register 0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic f_match(input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  // EX-stage operand forwarding; the younger MEM result takes priority over WB.
  always_comb begin
    w_fwd_a_E = FWD_RF;
    w_fwd_b_E = FWD_RF;
    if (i_reg_write_M && f_match(i_write_reg_M, i_rs_E)) begin
      w_fwd_a_E = FWD_MEM;
    end else if (i_reg_write_W && f_match(i_write_reg_W, i_rs_E)) begin
      w_fwd_a_E = FWD_WB;
    end
    if (i_reg_write_M && f_match(i_write_reg_M, i_rt_E)) begin
      w_fwd_b_E = FWD_MEM;
    end else if (i_reg_write_W && f_match(i_write_reg_W, i_rt_E)) begin
      w_fwd_b_E = FWD_WB;
    end
  end

  // Branch comparator in ID can only take an ALU result already sitting in MEM.
  always_comb begin
    w_fwd_a_D = i_reg_write_M && f_match(i_write_reg_M, i_rs_D);
    w_fwd_b_D = i_reg_write_M && f_match(i_write_reg_M, i_rt_D);
  end

  // Stall sources: load-use, branch operands not yet available, mul/div busy.
  always_comb begin
    w_lw_stall = i_mem_to_reg_E &&
                 (f_match(i_write_reg_E, i_rs_D) || f_match(i_write_reg_E, i_rt_D));
    w_br_stall = i_branch_D &&
                 ((i_reg_write_E &&
                   (f_match(i_write_reg_E, i_rs_D) || f_match(i_write_reg_E, i_rt_D))) ||
                  (i_mem_to_reg_M &&
                   (f_match(i_write_reg_M, i_rs_D) || f_match(i_write_reg_M, i_rt_D))));
    // The result is not readable until the cycle after md_done, so the done
    // cycle still stalls a dependent instruction.
    w_md_stall = r_md_busy && i_md_use_D;
    w_stall    = w_lw_stall || w_br_stall || w_md_stall;
    // A redirect seen while ID is frozen is dropped; the branch is still in ID
    // and re-resolves once the stall clears.
    w_flush_D  = i_pc_src_D && !w_stall;
  end

  // Mul/div sequencer: busy for exactly MD_LAT cycles, done flags the last one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_md_state <= ST_IDLE;
      r_md_cnt   <= '0;
      r_md_busy  <= 1'b0;
      r_md_done  <= 1'b0;
    end else begin
      case (r_md_state)
        ST_IDLE: begin
          // A start squashed into a bubble by flush_E never reaches the unit.
          if (i_md_start_E && !w_stall) begin
            r_md_state <= ST_BUSY;
            r_md_cnt   <= MD_LOAD;
            r_md_busy  <= 1'b1;
            r_md_done  <= (MD_LOAD == '0);
          end
        end
        ST_BUSY: begin
          // Starts arriving while busy (including the done cycle) are dropped.
          if (r_md_cnt == '0) begin
            r_md_state <= ST_IDLE;
            r_md_busy  <= 1'b0;
            r_md_done  <= 1'b0;
          end else begin
            r_md_cnt  <= r_md_cnt - MD_CW'(1);
            r_md_done <= (r_md_cnt == MD_CW'(1));
          end
        end
        default: begin
          r_md_state <= ST_IDLE;
          r_md_cnt   <= '0;
          r_md_busy  <= 1'b0;
          r_md_done  <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter of stalled fetch cycles, sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_forward_a_E = w_fwd_a_E;
  assign o_forward_b_E = w_fwd_b_E;
  assign o_forward_a_D = w_fwd_a_D;
  assign o_forward_b_D = w_fwd_b_D;
  assign o_stall_F     = w_stall;
  assign o_stall_D     = w_stall;
  assign o_flush_E     = w_stall;
  assign o_flush_D     = w_flush_D;
  assign o_md_busy     = r_md_busy;
  assign o_md_done     = r_md_done;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a cycle-level reference model (remaining
// mul/div cycles and a stall tally) checked against the DUT each cycle, plus
// directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
  logic              branch_D, pc_src_D, md_use_D;
  logic              reg_write_E, mem_to_reg_E, md_start_E;
  logic              reg_write_M, mem_to_reg_M, reg_write_W;
  logic [1:0]        forward_a_E, forward_b_E;
  logic              forward_a_D, forward_b_D;
  logic              stall_F, stall_D, flush_D, flush_E, md_busy, md_done;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  int m_rem = 0;
  int m_cnt = 0;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs_D(rs_D), .i_rt_D(rt_D), .i_branch_D(branch_D), .i_pc_src_D(pc_src_D),
    .i_md_use_D(md_use_D), .i_rs_E(rs_E), .i_rt_E(rt_E),
    .i_write_reg_E(write_reg_E), .i_reg_write_E(reg_write_E),
    .i_mem_to_reg_E(mem_to_reg_E), .i_md_start_E(md_start_E),
    .i_write_reg_M(write_reg_M), .i_reg_write_M(reg_write_M),
    .i_mem_to_reg_M(mem_to_reg_M), .i_write_reg_W(write_reg_W),
    .i_reg_write_W(reg_write_W),
    .o_forward_a_E(forward_a_E), .o_forward_b_E(forward_b_E),
    .o_forward_a_D(forward_a_D), .o_forward_b_D(forward_b_D),
    .o_stall_F(stall_F), .o_stall_D(stall_D), .o_flush_D(flush_D),
    .o_flush_E(flush_E), .o_md_busy(md_busy), .o_md_done(md_done),
    .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
    return (dst == src) && (dst != 0);
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [REG_AW-1:0] src);
    if (reg_write_M && dep(write_reg_M, src)) return 2'b10;
    if (reg_write_W && dep(write_reg_W, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit uses_e, uses_m;
    uses_e = dep(write_reg_E, rs_D) || dep(write_reg_E, rt_D);
    uses_m = dep(write_reg_M, rs_D) || dep(write_reg_M, rt_D);
    return (mem_to_reg_E && uses_e) ||
           (branch_D && ((reg_write_E && uses_e) || (mem_to_reg_M && uses_m))) ||
           ((m_rem > 0) && md_use_D);
  endfunction

  // Model: m_rem = mul/div cycles still to run; m_cnt = stall tally.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      m_cnt <= 0;
    end else begin
      if (m_rem > 0) m_rem <= m_rem - 1;
      else if (md_start_E && !m_stall()) m_rem <= MD_LAT;
      if (m_stall() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit s;
    s = m_stall();
    chk("fwd_a_E", forward_a_E, m_fwd_e(rs_E));
    chk("fwd_b_E", forward_b_E, m_fwd_e(rt_E));
    chk("fwd_a_D", forward_a_D, reg_write_M && dep(write_reg_M, rs_D));
    chk("fwd_b_D", forward_b_D, reg_write_M && dep(write_reg_M, rt_D));
    chk("stall_F", stall_F, s);
    chk("stall_D", stall_D, s);
    chk("flush_E", flush_E, s);
    chk("flush_D", flush_D, pc_src_D && !s);
    chk("md_busy", md_busy, m_rem > 0);
    chk("md_done", md_done, m_rem == 1);
    chk("stall_cnt", stall_cnt, m_cnt);
  end

  task automatic clear();
    rs_D = 0; rt_D = 0; branch_D = 0; pc_src_D = 0; md_use_D = 0;
    rs_E = 0; rt_E = 0; write_reg_E = 0; reg_write_E = 0; mem_to_reg_E = 0;
    md_start_E = 0; write_reg_M = 0; reg_write_M = 0; mem_to_reg_M = 0;
    write_reg_W = 0; reg_write_W = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clear();
    rst_n = 1'b0;
    #13;
    chk("rst_busy", md_busy, 0);
    chk("rst_cnt", stall_cnt, 0);
    tick();
    rst_n = 1'b1;

    // add $3 in MEM and WB both feed rs_E/rt_E: MEM wins, then WB alone
    clear();
    rs_E = 3; rt_E = 3; write_reg_M = 3; reg_write_M = 1; write_reg_W = 3; reg_write_W = 1;
    settle();
    chk("t1_fwd_a_mem", forward_a_E, 2'b10);
    chk("t1_fwd_b_mem", forward_b_E, 2'b10);
    tick();
    reg_write_M = 0;
    settle();
    chk("t1_fwd_a_wb", forward_a_E, 2'b01);

    // $0 never forwards or stalls
    tick(); clear();
    write_reg_M = 0; reg_write_M = 1; write_reg_W = 0; reg_write_W = 1; rs_E = 0;
    settle();
    chk("t2_fwd_zero", forward_a_E, 2'b00);
    tick(); clear();
    mem_to_reg_E = 1; reg_write_E = 1; write_reg_E = 0; branch_D = 1;
    settle();
    chk("t2_no_stall", stall_F, 0);

    // lw $5 in EX with beq on $5: stall, redirect suppressed
    tick(); clear();
    mem_to_reg_E = 1; reg_write_E = 1; write_reg_E = 5; rs_D = 5; branch_D = 1; pc_src_D = 1;
    settle();
    chk("t3_stall_F", stall_F, 1);
    chk("t3_stall_D", stall_D, 1);
    chk("t3_flush_E", flush_E, 1);
    chk("t3_flush_D", flush_D, 0);
    tick(); clear();
    pc_src_D = 1;
    settle();
    chk("t3_release", stall_F, 0);
    chk("t3_redirect", flush_D, 1);

    // beq on $7: ALU result in MEM forwards, load in MEM stalls
    tick(); clear();
    branch_D = 1; rs_D = 7; rt_D = 2; write_reg_M = 7; reg_write_M = 1;
    settle();
    chk("t4_fwd_a_D", forward_a_D, 1);
    chk("t4_fwd_b_D", forward_b_D, 0);
    chk("t4_no_stall", stall_F, 0);
    tick();
    mem_to_reg_M = 1;
    settle();
    chk("t4_lw_stall", stall_F, 1);
    tick(); clear();
    branch_D = 1; rt_D = 7; write_reg_M = 7; reg_write_M = 1;
    settle();
    chk("t4_fwd_b_D", forward_b_D, 1);
    chk("t4_fwd_a_D0", forward_a_D, 0);

    // mul/div start at cycle 0 with mflo in ID
    tick(); clear();
    md_start_E = 1; md_use_D = 1;
    settle();
    chk("t5_c0_busy", md_busy, 0);
    chk("t5_c0_stall", stall_F, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      md_start_E = (c == 4);
      md_use_D = 1;
      settle();
      chk("t5_busy", md_busy, 1);
      chk("t5_done", md_done, (c == 4));
      chk("t5_stall", stall_F, 1);
    end
    tick();
    md_start_E = 0;
    settle();
    chk("t5_c5_busy", md_busy, 0);
    chk("t5_c5_stall", stall_F, 0);

    // a start squashed by flush_E never launches
    tick(); clear();
    md_start_E = 1; mem_to_reg_E = 1; reg_write_E = 1; write_reg_E = 4; rt_D = 4;
    settle();
    chk("t5b_flush", flush_E, 1);
    tick(); clear();
    md_use_D = 1;
    settle();
    chk("t5b_no_busy", md_busy, 0);

    // async reset during BUSY cycle 2
    tick(); clear();
    md_start_E = 1;
    tick();
    md_start_E = 0; md_use_D = 1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", md_busy, 0);
    chk("t6_rst_done", md_done, 0);
    chk("t6_rst_cnt", stall_cnt, 0);
    chk("t6_rst_stall", stall_F, 0);
    #2;
    rst_n = 1'b1;

    // 20 stall cycles saturate a 4-bit counter at 15
    clear();
    for (int i = 0; i < 20; i++) begin
      tick();
      mem_to_reg_E = 1; reg_write_E = 1; write_reg_E = 9; rs_D = 9;
    end
    tick(); clear();
    settle();
    chk("t6_sat", stall_cnt, 15);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
